// File: rtl/rng_bit_stats.sv
// Block-based randomness health check: counts ones and bit transitions over
// 2^LOG2_WORDS 32-bit generator words and flags whether both stay near N/2.
//
// state     | meaning
// S_IDLE    | waiting for the first start after reset
// S_COLLECT | accepting valid words into the accumulators
// S_DONE    | block finished, results held until the next block completes
module rng_bit_stats #(
  parameter int unsigned LOG2_WORDS = 10,
  parameter int unsigned MONO_TOL   = 256,
  parameter int unsigned RUNS_TOL   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           data_in,
  input  logic                  data_valid,
  output logic                  busy,
  output logic [LOG2_WORDS+5:0] ones_count,
  output logic [LOG2_WORDS+5:0] trans_count,
  output logic                  result_valid,
  output logic                  pass
);

  localparam int unsigned CW = LOG2_WORDS + 6;
  localparam logic [CW-1:0] HALF = CW'(32'd1 << (LOG2_WORDS + 4));

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]            state;
  logic [LOG2_WORDS-1:0] words_left;
  logic [CW-1:0]         ones_acc;
  logic [CW-1:0]         trans_acc;
  logic                  first_word;
  logic                  prev_msb;

  logic [5:0]            word_ones;
  logic [5:0]            word_trans;
  logic [CW-1:0]         ones_next;
  logic [CW-1:0]         trans_next;
  logic [CW-1:0]         ones_diff;
  logic [CW-1:0]         trans_diff;
  logic                  pass_next;

  // The boundary transition links bit 31 of the previous word to bit 0 of this one.
  always_comb begin
    word_ones  = '0;
    word_trans = '0;
    for (int i = 0; i < 32; i++) word_ones = word_ones + 6'(data_in[i]);
    for (int i = 0; i < 31; i++) word_trans = word_trans + 6'(data_in[i] ^ data_in[i+1]);
    if (!first_word && (data_in[0] ^ prev_msb)) word_trans = word_trans + 6'd1;
  end

  always_comb begin
    ones_next  = ones_acc + CW'(word_ones);
    trans_next = trans_acc + CW'(word_trans);
    ones_diff  = (ones_next >= HALF) ? (ones_next - HALF) : (HALF - ones_next);
    trans_diff = (trans_next >= HALF) ? (trans_next - HALF) : (HALF - trans_next);
    pass_next  = (32'(ones_diff) <= MONO_TOL) && (32'(trans_diff) <= RUNS_TOL);
  end

  assign busy = (state == S_COLLECT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      words_left   <= '0;
      ones_acc     <= '0;
      trans_acc    <= '0;
      first_word   <= 1'b0;
      prev_msb     <= 1'b0;
      ones_count   <= '0;
      trans_count  <= '0;
      pass         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_COLLECT;
            words_left <= '1;
            ones_acc   <= '0;
            trans_acc  <= '0;
            first_word <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (data_valid) begin
            ones_acc   <= ones_next;
            trans_acc  <= trans_next;
            prev_msb   <= data_in[31];
            first_word <= 1'b0;
            words_left <= words_left - LOG2_WORDS'(1);
            if (words_left == '0) begin
              state        <= S_DONE;
              ones_count   <= ones_next;
              trans_count  <= trans_next;
              pass         <= pass_next;
              result_valid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_bit_stats.sv
// Directed bench for rng_bit_stats with 4-word blocks (N=128, tolerances 8).
module tb_rng_bit_stats;

  localparam int unsigned LW = 2;
  localparam int unsigned CW = LW + 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   data_in;
  logic          data_valid;
  logic          busy;
  logic [CW-1:0] ones_count;
  logic [CW-1:0] trans_count;
  logic          result_valid;
  logic          pass;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_count = 0;
  logic [31:0] last_ones  = '0;
  logic [31:0] last_trans = '0;
  logic [31:0] last_pass  = '0;

  rng_bit_stats #(.LOG2_WORDS(LW), .MONO_TOL(8), .RUNS_TOL(8)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
    .busy(busy), .ones_count(ones_count), .trans_count(trans_count),
    .result_valid(result_valid), .pass(pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (result_valid) rv_count <= rv_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete block; optional random gaps, start noise inside COLLECT and
  // a valid word presented on the start cycle (which must not be counted).
  task automatic run_block(input logic [31:0] w, input int max_gap, input bit start_noise,
                           input bit dv_with_start, input logic [31:0] e_ones,
                           input logic [31:0] e_trans, input logic [31:0] e_pass);
    int rv0;
    int gap;
    start      = 1'b1;
    data_valid = dv_with_start;
    data_in    = 32'hFFFF_FFFF;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
    check("busy_after_start", busy, 1);
    check("hold_ones", ones_count, last_ones);
    check("hold_trans", trans_count, last_trans);
    check("hold_pass", pass, last_pass);
    rv0 = rv_count;
    for (int i = 0; i < 4; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        data_valid = 1'b0;
        data_in    = 32'hFFFF_FFFF;
        start      = start_noise;
        step();
        check("busy_in_gap", busy, 1);
      end
      start      = start_noise;
      data_in    = w;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      start      = 1'b0;
      if (i < 3) begin
        check("no_early_result", result_valid, 0);
        check("busy_mid_block", busy, 1);
      end else begin
        check("result_valid", result_valid, 1);
        check("busy_at_result", busy, 0);
        check("ones_count", ones_count, e_ones);
        check("trans_count", trans_count, e_trans);
        check("pass", pass, e_pass);
      end
    end
    step();
    check("result_pulse_width", result_valid, 0);
    check("result_pulse_count", rv_count - rv0, 1);
    last_ones  = e_ones;
    last_trans = e_trans;
    last_pass  = e_pass;
  endtask

  initial begin
    int rvb;
    rst        = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_ones", ones_count, 0);
    check("rst_trans", trans_count, 0);
    check("rst_pass", pass, 0);
    check("rst_rv", result_valid, 0);
    step();
    rst = 1'b1;

    // data_valid in IDLE is ignored and the block waits for start
    data_valid = 1'b1;
    data_in    = 32'hFFFF_FFFF;
    repeat (3) step();
    data_valid = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_rv", result_valid, 0);
    check("idle_ones", ones_count, 0);

    run_block(32'hCCCC_CCCC, 0, 1'b0, 1'b0, 64, 63, 1);
    run_block(32'hAAAA_AAAA, 0, 1'b0, 1'b0, 64, 127, 0);
    run_block(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 128, 0, 0);

    // data_valid in DONE is ignored
    data_valid = 1'b1;
    data_in    = 32'h0000_0000;
    repeat (3) step();
    data_valid = 1'b0;
    check("done_busy", busy, 0);
    check("done_rv", result_valid, 0);
    check("done_ones", ones_count, 128);

    run_block(32'h0000_0000, 0, 1'b0, 1'b1, 0, 0, 0);
    run_block(32'hCCCC_CCCC, 5, 1'b1, 1'b0, 64, 63, 1);

    // reset in mid-block drops the partial block without a result
    rvb   = rv_count;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_in    = 32'hFFFF_FFFF;
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ones", ones_count, 0);
    check("midrst_trans", trans_count, 0);
    check("midrst_pass", pass, 0);
    check("midrst_rv", result_valid, 0);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    check("midrst_no_result", rv_count - rvb, 0);
    check("midrst_idle", busy, 0);
    last_ones  = '0;
    last_trans = '0;
    last_pass  = '0;
    run_block(32'hFFFF_0000, 2, 1'b0, 1'b0, 64, 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
